// File: rtl/mem_stage_if.sv
// ============================================================================
//  Module      : mem_stage_if
//  Description : Data-memory request/acknowledge bus between mem_stage and
//                the data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  dmemReq;
    logic                  dmemWe;
    logic [ADDR_WIDTH-1:0] dmemAddr;
    logic [31:0]           dmemWdata;
    logic [3:0]            dmemBe;
    logic [31:0]           dmemRdata;
    logic                  dmemAck;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
        input  dmemRdata, dmemAck
    );

    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
        output dmemRdata, dmemAck
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage. Issues loads/stores over a
//                variable-latency req/ack bus, aligns/extends load data and
//                registers the writeback bundle. Optional misaligned-access
//                trap enabled by defining MEM_MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [31:0] alu,
    input  wire logic        aluToReg,
    input  wire logic [1:0]  memSize,
    input  wire logic [1:0]  memOp,
    input  wire logic        memUnsigned,
    input  wire logic [4:0]  rd,
    input  wire logic [31:0] rs2Val,
    output logic             stallOut,
    mem_stage_if.master      dmem,
    output logic [31:0]      wbVal,
    output logic [4:0]       wbRd,
    output logic             wbWe,
    output logic             misaligned
);

    localparam logic [0:0] C_IDLE     = 1'b0;
    localparam logic [0:0] C_WAIT     = 1'b1;
    localparam logic [1:0] C_OP_LOAD  = 2'b01;
    localparam logic [1:0] C_OP_STORE = 2'b10;
    localparam logic [1:0] C_SZ_BYTE  = 2'b00;
    localparam logic [1:0] C_SZ_HALF  = 2'b01;

    logic [0:0]            state_q, state_d;
    logic                  dmemReq_q, dmemReq_d;
    logic                  dmemWe_q, dmemWe_d;
    logic [ADDR_WIDTH-1:0] dmemAddr_q, dmemAddr_d;
    logic [31:0]           dmemWdata_q, dmemWdata_d;
    logic [3:0]            dmemBe_q, dmemBe_d;
    logic [31:0]           wbVal_q, wbVal_d;
    logic [4:0]            wbRd_q, wbRd_d;
    logic                  wbWe_q, wbWe_d;

    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_is_mem;
    logic                  w_misalign;
    logic                  w_stall;
    logic [1:0]            w_off;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_ext;

    assign w_off      = alu[1:0];
    assign w_is_load  = (memOp == C_OP_LOAD);
    assign w_is_store = (memOp == C_OP_STORE);
    assign w_is_mem   = w_is_load | w_is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;
    assign w_misalign = ((memSize == C_SZ_HALF) && w_off[0]) ||
                        (memSize[1] && (w_off != 2'b00));
    assign misaligned = misaligned_q;
`else
    assign w_misalign = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Lane steering for stores; size 2'b11 falls into the word case.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = rs2Val;
        case (memSize)
            C_SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{rs2Val[7:0]}};
            end
            C_SZ_HALF: begin
                w_be    = 4'b0011 << {w_off[1], 1'b0};
                w_wdata = {2{rs2Val[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = dmem.dmemRdata[7:0];
        case (w_off)
            2'd0:    w_byte = dmem.dmemRdata[7:0];
            2'd1:    w_byte = dmem.dmemRdata[15:8];
            2'd2:    w_byte = dmem.dmemRdata[23:16];
            default: w_byte = dmem.dmemRdata[31:24];
        endcase
        w_half     = w_off[1] ? dmem.dmemRdata[31:16] : dmem.dmemRdata[15:0];
        w_load_ext = dmem.dmemRdata;
        case (memSize)
            C_SZ_BYTE: w_load_ext = memUnsigned ? {24'd0, w_byte}
                                                : {{24{w_byte[7]}}, w_byte};
            C_SZ_HALF: w_load_ext = memUnsigned ? {16'd0, w_half}
                                                : {{16{w_half[15]}}, w_half};
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:  if (w_is_mem && !w_misalign) state_d = C_WAIT;
            C_WAIT:  if (dmem.dmemAck)            state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        w_stall     = 1'b0;
        dmemReq_d   = dmemReq_q;
        dmemWe_d    = dmemWe_q;
        dmemAddr_d  = dmemAddr_q;
        dmemWdata_d = dmemWdata_q;
        dmemBe_d    = dmemBe_q;
        wbVal_d     = wbVal_q;
        wbRd_d      = wbRd_q;
        wbWe_d      = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif
        case (state_q)
            C_IDLE: begin
                if (!w_is_mem) begin
                    dmemReq_d = 1'b0;
                    wbVal_d   = alu;
                    wbRd_d    = rd;
                    wbWe_d    = aluToReg && (rd != 5'd0);
                end else if (w_misalign) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    misaligned_d = 1'b1;
`endif
                end else begin
                    // Enables qualify write lanes only; a load returns the whole word.
                    w_stall     = 1'b1;
                    dmemReq_d   = 1'b1;
                    dmemWe_d    = w_is_store;
                    dmemAddr_d  = {alu[ADDR_WIDTH-1:2], 2'b00};
                    dmemBe_d    = w_is_store ? w_be : 4'b0000;
                    dmemWdata_d = w_is_store ? w_wdata : 32'd0;
                end
            end
            C_WAIT: begin
                if (dmem.dmemAck) begin
                    dmemReq_d = 1'b0;
                    if (w_is_load) begin
                        wbVal_d = w_load_ext;
                        wbRd_d  = rd;
                        wbWe_d  = (rd != 5'd0);
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Upstream hold is forced low while reset is asserted.
    assign stallOut = w_stall & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmemReq_q   <= 1'b0;
            dmemWe_q    <= 1'b0;
            dmemAddr_q  <= '0;
            dmemWdata_q <= 32'd0;
            dmemBe_q    <= 4'd0;
            wbVal_q     <= 32'd0;
            wbRd_q      <= 5'd0;
            wbWe_q      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            dmemReq_q   <= dmemReq_d;
            dmemWe_q    <= dmemWe_d;
            dmemAddr_q  <= dmemAddr_d;
            dmemWdata_q <= dmemWdata_d;
            dmemBe_q    <= dmemBe_d;
            wbVal_q     <= wbVal_d;
            wbRd_q      <= wbRd_d;
            wbWe_q      <= wbWe_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_q <= misaligned_d;
`endif
        end
    end

    assign dmem.dmemReq   = dmemReq_q;
    assign dmem.dmemWe    = dmemWe_q;
    assign dmem.dmemAddr  = dmemAddr_q;
    assign dmem.dmemWdata = dmemWdata_q;
    assign dmem.dmemBe    = dmemBe_q;
    assign wbVal          = wbVal_q;
    assign wbRd           = wbRd_q;
    assign wbWe           = wbWe_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic [31:0] alu;
    logic        aluToReg;
    logic [1:0]  memSize;
    logic [1:0]  memOp;
    logic        memUnsigned;
    logic [4:0]  rd;
    logic [31:0] rs2Val;
    logic        stallOut;
    logic [31:0] wbVal;
    logic [4:0]  wbRd;
    logic        wbWe;
    logic        misaligned;

    int n_checks = 0;
    int n_fails  = 0;

    mem_stage_if #(.ADDR_WIDTH(32)) dmem_bus ();

    mem_stage #(.ADDR_WIDTH(32)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .alu         (alu),
        .aluToReg    (aluToReg),
        .memSize     (memSize),
        .memOp       (memOp),
        .memUnsigned (memUnsigned),
        .rd          (rd),
        .rs2Val      (rs2Val),
        .stallOut    (stallOut),
        .dmem        (dmem_bus.master),
        .wbVal       (wbVal),
        .wbRd        (wbRd),
        .wbWe        (wbWe),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [4:0] r,
                           input logic [31:0] s2, input logic toreg);
        memOp       = op;
        memSize     = sz;
        memUnsigned = uns;
        alu         = a;
        rd          = r;
        rs2Val      = s2;
        aluToReg    = toreg;
    endtask

    // Pulse ack in the current WAIT cycle, then return one tick later.
    task automatic ack_now(input logic [31:0] rdata);
        dmem_bus.dmemRdata = rdata;
        dmem_bus.dmemAck   = 1'b1;
        #1;
        check_eq("stall_ack_cycle", {31'd0, stallOut}, 32'd0);
        tick();
        dmem_bus.dmemAck   = 1'b0;
        dmem_bus.dmemRdata = 32'd0;
    endtask

    task automatic bubble();
        present(2'b00, 2'b00, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        reset              = 1'b0;
        dmem_bus.dmemAck   = 1'b0;
        dmem_bus.dmemRdata = 32'd0;
        present(2'b01, 2'b10, 1'b0, 32'h0000_0100, 5'd1, 32'd0, 1'b1);

        // Reset state, with a load pending at the input
        tick();
        check_eq("rst_stall", {31'd0, stallOut}, 32'd0);
        check_eq("rst_req",   {31'd0, dmem_bus.dmemReq}, 32'd0);
        check_eq("rst_wbWe",  {31'd0, wbWe}, 32'd0);
        check_eq("rst_wbVal", wbVal, 32'd0);
        check_eq("rst_misal", {31'd0, misaligned}, 32'd0);
        bubble();
        reset = 1'b1;

        // ALU pass-through
        tick();
        present(2'b00, 2'b00, 1'b0, 32'h0000_1234, 5'd5, 32'd0, 1'b1);
        #1;
        check_eq("alu_stall", {31'd0, stallOut}, 32'd0);
        tick();
        check_eq("alu_wbVal", wbVal, 32'h0000_1234);
        check_eq("alu_wbRd",  {27'd0, wbRd}, 32'd5);
        check_eq("alu_wbWe",  {31'd0, wbWe}, 32'd1);

        // Signed byte load, ack in third WAIT cycle
        present(2'b01, 2'b00, 1'b0, 32'h0000_0103, 5'd7, 32'd0, 1'b0);
        #1;
        check_eq("lb_stall_issue", {31'd0, stallOut}, 32'd1);
        tick();
        check_eq("lb_req",  {31'd0, dmem_bus.dmemReq}, 32'd1);
        check_eq("lb_we",   {31'd0, dmem_bus.dmemWe}, 32'd0);
        check_eq("lb_addr", dmem_bus.dmemAddr, 32'h0000_0100);
        check_eq("lb_be",   {28'd0, dmem_bus.dmemBe}, 32'd0);
        check_eq("lb_bubble", {31'd0, wbWe}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            check_eq("lb_stall_wait", {31'd0, stallOut}, 32'd1);
            tick();
            check_eq("lb_req_held", {31'd0, dmem_bus.dmemReq}, 32'd1);
            check_eq("lb_addr_held", dmem_bus.dmemAddr, 32'h0000_0100);
        end
        ack_now(32'h80FF_0000);
        check_eq("lb_wbVal", wbVal, 32'hFFFF_FF80);
        check_eq("lb_wbWe",  {31'd0, wbWe}, 32'd1);
        check_eq("lb_wbRd",  {27'd0, wbRd}, 32'd7);
        check_eq("lb_req_drop", {31'd0, dmem_bus.dmemReq}, 32'd0);

        // Unsigned byte load, ack in first WAIT cycle
        present(2'b01, 2'b00, 1'b1, 32'h0000_0103, 5'd7, 32'd0, 1'b0);
        tick();
        ack_now(32'h80FF_0000);
        check_eq("lbu_wbVal", wbVal, 32'h0000_0080);
        check_eq("lbu_wbWe",  {31'd0, wbWe}, 32'd1);

        // Signed half load from upper lane
        present(2'b01, 2'b01, 1'b0, 32'h0000_0302, 5'd9, 32'd0, 1'b0);
        tick();
        ack_now(32'h8001_1234);
        check_eq("lh_wbVal", wbVal, 32'hFFFF_8001);

        // Half store
        present(2'b10, 2'b01, 1'b0, 32'h0000_0202, 5'd4, 32'hDEAD_BEEF, 1'b0);
        tick();
        check_eq("sh_we",    {31'd0, dmem_bus.dmemWe}, 32'd1);
        check_eq("sh_addr",  dmem_bus.dmemAddr, 32'h0000_0200);
        check_eq("sh_be",    {28'd0, dmem_bus.dmemBe}, 32'h0000_000C);
        check_eq("sh_wdata", dmem_bus.dmemWdata, 32'hBEEF_BEEF);
        tick();
        ack_now(32'd0);
        check_eq("sh_wbWe", {31'd0, wbWe}, 32'd0);

        // Byte store at offset 1
        present(2'b10, 2'b00, 1'b0, 32'h0000_0401, 5'd4, 32'h1234_56AB, 1'b0);
        tick();
        check_eq("sb_be",    {28'd0, dmem_bus.dmemBe}, 32'h0000_0002);
        check_eq("sb_wdata", dmem_bus.dmemWdata, 32'hABAB_ABAB);
        ack_now(32'd0);

        // Word load to x0, then an ALU op right behind it
        present(2'b01, 2'b10, 1'b0, 32'h0000_0500, 5'd0, 32'd0, 1'b0);
        tick();
        ack_now(32'hCAFE_F00D);
        check_eq("lw_x0_wbWe", {31'd0, wbWe}, 32'd0);
        present(2'b00, 2'b00, 1'b0, 32'h0000_0055, 5'd3, 32'd0, 1'b1);
        #1;
        check_eq("lw_x0_idle_stall", {31'd0, stallOut}, 32'd0);
        tick();
        check_eq("after_lw_wbVal", wbVal, 32'h0000_0055);
        check_eq("after_lw_wbWe",  {31'd0, wbWe}, 32'd1);

        // aluToReg with rd=0 never writes
        present(2'b00, 2'b00, 1'b0, 32'h0000_0066, 5'd0, 32'd0, 1'b1);
        tick();
        check_eq("x0_alu_wbWe", {31'd0, wbWe}, 32'd0);

        // Reset during WAIT abandons the access
        present(2'b01, 2'b10, 1'b0, 32'h0000_0600, 5'd8, 32'd0, 1'b0);
        tick();
        check_eq("rw_req_before", {31'd0, dmem_bus.dmemReq}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("rw_req_async", {31'd0, dmem_bus.dmemReq}, 32'd0);
        check_eq("rw_stall",     {31'd0, stallOut}, 32'd0);
        tick();
        reset = 1'b1;
        present(2'b00, 2'b00, 1'b0, 32'h0000_0077, 5'd9, 32'd0, 1'b1);
        dmem_bus.dmemAck   = 1'b1;
        dmem_bus.dmemRdata = 32'hFFFF_FFFF;
        #1;
        check_eq("rw_late_ack_stall", {31'd0, stallOut}, 32'd0);
        tick();
        dmem_bus.dmemAck = 1'b0;
        check_eq("rw_wbVal", wbVal, 32'h0000_0077);
        check_eq("rw_wbWe",  {31'd0, wbWe}, 32'd1);
        check_eq("rw_req",   {31'd0, dmem_bus.dmemReq}, 32'd0);

        // Word load at an offset address
        present(2'b01, 2'b10, 1'b0, 32'h0000_0102, 5'd6, 32'd0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        check_eq("mis_stall", {31'd0, stallOut}, 32'd0);
        tick();
        check_eq("mis_pulse", {31'd0, misaligned}, 32'd1);
        check_eq("mis_req",   {31'd0, dmem_bus.dmemReq}, 32'd0);
        check_eq("mis_wbWe",  {31'd0, wbWe}, 32'd0);
        bubble();
        tick();
        check_eq("mis_pulse_end", {31'd0, misaligned}, 32'd0);
`else
        tick();
        check_eq("off_lw_req",  {31'd0, dmem_bus.dmemReq}, 32'd1);
        check_eq("off_lw_addr", dmem_bus.dmemAddr, 32'h0000_0100);
        check_eq("off_lw_misal", {31'd0, misaligned}, 32'd0);
        ack_now(32'h1122_3344);
        check_eq("off_lw_wbVal", wbVal, 32'h1122_3344);
        check_eq("off_lw_wbWe",  {31'd0, wbWe}, 32'd1);
        bubble();
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute latch. Consumes its registered outputs: ALU result, aluToReg, memSize, memOp, rd and rs2Val.
- Performs load/store over a variable-latency data-memory handshake. Aligns and extends load data.
- Produces the registered writeback bundle.
- Drives a stall back to the upstream latches while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of dmemAddr. It is a byte address and bits [1:0] are always driven 0.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- alu  in  32  ALU result / effective byte address
- aluToReg  in  1  result is written to rd
- memSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
- memOp  in  2  00 none, 01 load, 10 store, 11 treated as none
- memUnsigned  in  1  load zero-extends when 1
- rd  in  5  destination register
- rs2Val  in  32  store data
- stallOut  out  1  upstream hold (combinational)
- dmemReq  out  1  access request (registered)
- dmemWe  out  1  1 = write
- dmemAddr  out  ADDR_WIDTH  word-aligned address
- dmemWdata  out  32  lane-replicated store data
- dmemBe  out  4  byte enables
- dmemRdata  in  32  read data, valid with dmemAck
- dmemAck  in  1  one-cycle completion pulse
- wbVal  out  32  writeback value
- wbRd  out  5  writeback register
- wbWe  out  1  writeback enable
- misaligned  out  1  one-cycle trap pulse (feature dependent)

Behaviour:
- Reset: asynchronous, active-low. On assertion, all registered outputs go to 0, state goes to IDLE, and stallOut reads 0.
- FSM has two states: IDLE and WAIT.
- IDLE, memOp none:
  - Next edge: wbVal=alu, wbRd=rd, wbWe=aluToReg && rd!=0.
  - Latency is 1 cycle and stallOut=0.
- IDLE, memOp load/store:
  - stallOut=1 in the same cycle.
  - Next edge: dmemReq=1, dmemWe=(store), dmemAddr={alu[ADDR_WIDTH-1:2],2'b00}, dmemBe and dmemWdata computed as below, wbWe=0, then go to WAIT.
- WAIT, dmemAck=0:
  - Hold every dmem output stable.
  - wbWe=0 (bubble); stallOut=1.
- WAIT, dmemAck=1:
  - stallOut=0 in that cycle, so upstream advances at the same edge.
  - At that edge: dmemReq=0; go to IDLE.
  - Load: wbVal=extended data, wbRd=rd, wbWe=(rd!=0).
  - Store: wbWe=0.
- Load latency is therefore at minimum 2 cycles from presentation to wbWe.
- Upstream inputs are held stable by stallOut throughout WAIT. The stage does not re-sample them.
- dmemAck while in IDLE is ignored.
- Byte enables (o = alu[1:0]):
  - byte: 4'b0001<<o
  - half: 4'b0011<<{o[1],1'b0}
  - word: 4'b1111
- Store data:
  - byte: {4{rs2Val[7:0]}}
  - half: {2{rs2Val[15:0]}}
  - word: rs2Val
- Load extraction:
  - byte: lane dmemRdata[8*o+:8]
  - half: lane dmemRdata[16*o[1]+:16]
  - Sign-extend unless memUnsigned=1; word is passed through.
- rd==0 never produces wbWe=1.
- Reset asserted during WAIT abandons the access: dmemReq drops asynchronously. The memory side must tolerate a dropped request.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with o[0]=1, or a word access with o!=0, issues no request and stays in IDLE.
  - misaligned pulses 1 for one cycle at the next edge; wbWe=0; stallOut=0.
- Undefined:
  - misaligned is tied 0.
  - Offending low address bits are ignored: half uses o[1], word uses lane 0. The access proceeds normally.

Test Plan:
- ALU op, alu=0x0000_1234, rd=5, aluToReg=1, memOp=00 -> next edge wbVal=0x1234, wbRd=5, wbWe=1; stallOut never 1.
- Load byte signed, alu=0x103, rdata=0x80FF_0000, ack 3 cycles after req:
  - dmemAddr=0x100, dmemBe=0000 with dmemWe=0.
  - stallOut high until the ack cycle.
  - Then wbVal=0xFFFF_FF80, wbWe=1.
- Same load with memUnsigned=1 -> wbVal=0x0000_0080.
- Store half, alu=0x202, rs2Val=0xDEAD_BEEF -> dmemWe=1, dmemBe=1100, dmemWdata=0xBEEF_BEEF; after ack, wbWe=0.
- Load word with rd=0, ack in first WAIT cycle -> wbWe stays 0; stage returns to IDLE in 2 cycles.
- Reset pulse low during WAIT -> dmemReq=0 immediately; later ack ignored; next memOp=00 instruction writes back in 1 cycle. With MEM_MISALIGN_TRAP_EN, word load at 0x102 -> misaligned=1 for one cycle, no dmemReq.
